// File: rtl/main_display_pkg.sv
// Shared constants for the scan-code viewer: segment glyphs, one-cold anode codes, break code.
package main_display_pkg;

    typedef enum logic [1:0] {
        SEL_D0 = 2'd0,
        SEL_D1 = 2'd1,
        SEL_D2 = 2'd2,
        SEL_D3 = 2'd3
    } digit_sel_e;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    localparam logic [6:0] SEG_OFF    = 7'b1111111;
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [3:0] an_for_sel(input digit_sel_e sel);
        logic [3:0] an;
        an = AN_DIG0;
        case (sel)
            SEL_D0: an = AN_DIG0;
            SEL_D1: an = AN_DIG1;
            SEL_D2: an = AN_DIG2;
            SEL_D3: an = AN_DIG3;
            default: an = AN_DIG0;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg
    import main_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/main_display.sv
// Shows keycode[15:0] as four hex digits on a multiplexed common-anode display.
// Optional macro BREAK_DP_EN lights DP on digit 0 while a break code sits in disp[15:8].
module main_display
    import main_display_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] keycode,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        DP
);

    localparam logic [REFRESH_BITS-1:0] CNT_STEP = REFRESH_BITS'(1);

    logic [REFRESH_BITS-1:0] counter_q, counter_d;
    logic [15:0]             disp_q, disp_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [3:0]              nibble;
    logic [6:0]              seg_lut;
    digit_sel_e              sel;
    logic                    unused_keycode_hi;

    // Older history bytes are not shown.
    assign unused_keycode_hi = ^keycode[31:16];

    assign sel    = digit_sel_e'(counter_q[REFRESH_BITS-1 -: 2]);
    assign nibble = disp_q[{sel, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg    (seg_lut)
    );

    always_comb begin
        counter_d = counter_q + CNT_STEP;
        disp_d    = keycode[15:0];
        an_d      = an_for_sel(sel);
        seg_d     = seg_lut;
`ifdef BREAK_DP_EN
        dp_d      = !((sel == SEL_D0) && (disp_q[15:8] == BREAK_CODE));
`else
        dp_d      = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q <= '0;
            disp_q    <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            counter_q <= counter_d;
            disp_q    <= disp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_main_display.sv
// Scoreboard bench for main_display with REFRESH_BITS=4 (4 clocks per digit).
module tb_main_display;

    logic        clk;
    logic        reset;
    logic [31:0] keycode;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic        DP;

    main_display #(.REFRESH_BITS(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .keycode (keycode),
        .SEG     (SEG),
        .AN      (AN),
        .DP      (DP)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    localparam out_t RESET_OUT = {4'b1111, 7'b1111111, 1'b1};

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    out_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          n_edges     = 0;
    logic [15:0] shown       = 16'h0000;

    // Reference: after the n-th edge since release the digit slot is ((n-1)/4)%4,
    // showing the keycode that was applied two edges earlier.
    task automatic push_expect(input logic rst_v, input logic [31:0] kc_v);
        out_t       e;
        int         slot;
        logic [3:0] nib;
        if (!rst_v) begin
            e       = RESET_OUT;
            n_edges = 0;
            shown   = 16'h0000;
        end else begin
            slot   = (n_edges / 4) % 4;
            nib    = 4'((shown >> (4 * slot)) & 16'h000F);
            e.an   = 4'b1111 & ~(4'b0001 << slot);
            e.seg  = seg_ref[nib];
            e.dp   = 1'b1;
`ifdef BREAK_DP_EN
            if (slot == 0 && shown[15:8] == 8'hF0) e.dp = 1'b0;
`endif
            shown   = kc_v[15:0];
            n_edges = n_edges + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst_v, input logic [31:0] kc_v);
        logic was_run;
        @(negedge clk);
        was_run = reset;
        reset   = rst_v;
        keycode = kc_v;
        #1;
        if (was_run && !rst_v) begin
            vectors = vectors + 1;
            if ({AN, SEG, DP} !== RESET_OUT) begin
                miscompares = miscompares + 1;
                $display("FAIL async_reset t=%0t got AN=%b SEG=%b DP=%b want AN=1111 SEG=1111111 DP=1",
                         $time, AN, SEG, DP);
            end
        end
        push_expect(rst_v, kc_v);
    endtask

    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            vectors = vectors + 1;
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL scoreboard_empty t=%0t got AN=%b SEG=%b DP=%b want a queued entry",
                         $time, AN, SEG, DP);
            end else begin
                e = exp_q.pop_front();
                if ({AN, SEG, DP} !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL display_out t=%0t got AN=%b SEG=%b DP=%b want AN=%b SEG=%b DP=%b",
                             $time, AN, SEG, DP, e.an, e.seg, e.dp);
                end
            end
        end
    end

    initial begin
        logic [31:0] kc;
        int          guard;
        reset   = 1'b0;
        keycode = 32'h0;
        push_expect(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);

        repeat (20) step(1'b1, 32'hAAAAAA16);
        repeat (48) step(1'b1, 32'hAAAA161E);

        kc = $urandom;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                kc = $urandom;
                if ($urandom_range(0, 3) == 0) kc[15:8] = 8'hF0;
            end
            step(1'b1, kc);
        end

        repeat (32) step(1'b1, 32'h0000F01C);

        // Walk into the middle of the AN=1011 slot, then hit reset between edges.
        guard = 0;
        while ((n_edges % 16) != 10 && guard < 64) begin
            step(1'b1, 32'h1234BEEF);
            guard = guard + 1;
        end
        if (guard >= 64) begin
            miscompares = miscompares + 1;
            $display("FAIL reach_digit2 got guard=%0d want <64", guard);
        end
        repeat (3) step(1'b0, 32'h1234BEEF);
        repeat (40) step(1'b1, 32'h5678C0DE);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
